hazard_ctrl_pipe: RTL and testbench

Execute-side counterpart of the decode-stage control register in the 5-stage RISC pipeline. It consumes the E-stage control bits and register addresses, carries the write-back control through the Memory and Writeback stages, resolves the branch/jump redirect, and produces the stall, flush and forwarding controls. Its `FlushE` output drives the `clr` input of the decode-stage control register. Saturating stall and flush event counters are kept for performance debug.

---
 rtl/hazard_ctrl_pipe.sv | 72 +++++++
 tb/tb_hazard_ctrl_pipe.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_pipe.sv
// hazard_ctrl_pipe: E->M->W control pipeline, redirect, load-use stall, forwarding and event counters.
module hazard_ctrl_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             JumpE,
    input  logic             BranchE,
    input  logic [1:0]       ResultSrcE,
    input  logic             ZeroE,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic [1:0]       ResultSrcM,
    output logic [4:0]       RdM,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic [4:0]       RdW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             PCSrcE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);
    logic lw_stall;
    always_comb begin
        PCSrcE    = JumpE | (BranchE & ZeroE);
        lw_stall  = (ResultSrcE == 2'b01) & (|RdE) & ((Rs1D == RdE) | (Rs2D == RdE));
        StallF    = lw_stall & ~PCSrcE;
        StallD    = StallF;
        FlushD    = PCSrcE;
        FlushE    = lw_stall | PCSrcE;
        ForwardAE = (|Rs1E & RegWriteM & (Rs1E == RdM)) ? 2'b10 :
                    (|Rs1E & RegWriteW & (Rs1E == RdW)) ? 2'b01 : 2'b00;
        ForwardBE = (|Rs2E & RegWriteM & (Rs2E == RdM)) ? 2'b10 :
                    (|Rs2E & RegWriteW & (Rs2E == RdW)) ? 2'b01 : 2'b00;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            RdM        <= 5'd0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            RdW        <= 5'd0;
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RdM        <= RdE;
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            RdW        <= RdM;
            // counters stick at all-ones until the next reset
            if (StallF && !(&StallCount)) StallCount <= StallCount + CNT_W'(1);
            if (PCSrcE && !(&FlushCount)) FlushCount <= FlushCount + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// tb_hazard_ctrl_pipe: directed checks of pipeline registers, forwarding, stalls, flushes and counters.
module tb_hazard_ctrl_pipe;
    localparam int CNT_W = 4;
    logic clk, reset;
    logic RegWriteE, MemWriteE, JumpE, BranchE, ZeroE;
    logic [1:0] ResultSrcE;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic RegWriteM, MemWriteM, RegWriteW, PCSrcE, StallF, StallD, FlushD, FlushE;
    logic [1:0] ResultSrcM, ResultSrcW, ForwardAE, ForwardBE;
    logic [4:0] RdM, RdW;
    logic [CNT_W-1:0] StallCount, FlushCount;
    int total = 0;
    int bad = 0;

    hazard_ctrl_pipe #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ResultSrcE(ResultSrcE), .ZeroE(ZeroE),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .PCSrcE(PCSrcE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        {RegWriteE, MemWriteE, JumpE, BranchE, ZeroE} = '0;
        ResultSrcE = 2'b00;
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE} = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        {RegWriteE, MemWriteE, JumpE, BranchE, ZeroE} = 5'($urandom) | 5'b10000;
        ResultSrcE = 2'($urandom);
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE} = 25'($urandom) | 25'd1;
        step();
        step();
        chk("rst_regwm", RegWriteM, 0);
        chk("rst_rdm", RdM, 0);
        chk("rst_regww", RegWriteW, 0);
        chk("rst_memwm", MemWriteM, 0);
        chk("rst_cnts", {StallCount, FlushCount}, 0);
        clear_in();
        #2 reset = 1'b1;
        #1;
        chk("rel_regwm", RegWriteM, 0);
        chk("rel_fwd", {ForwardAE, ForwardBE}, 0);

        // forward priority: two writers of x5, M must win
        RegWriteE = 1'b1; RdE = 5'd5;
        step();
        chk("em_regwm", RegWriteM, 1);
        chk("em_rdm", RdM, 5);
        step();
        chk("ew_regww", RegWriteW, 1);
        chk("ew_rdw", RdW, 5);
        RegWriteE = 1'b0; RdE = 5'd0; Rs1E = 5'd5;
        #1;
        chk("fwdA_m", ForwardAE, 2'b10);
        step();
        Rs1E = 5'd0; Rs2E = 5'd5;
        #1;
        chk("fwdB_w", ForwardBE, 2'b01);
        chk("fwdA_x0", ForwardAE, 2'b00);

        // x0 never forwards nor stalls
        Rs2E = 5'd0; RegWriteE = 1'b1; RdE = 5'd0;
        step();
        RegWriteE = 1'b0; Rs1E = 5'd0; ResultSrcE = 2'b01; Rs1D = 5'd0;
        #1;
        chk("x0_fwd", ForwardAE, 2'b00);
        chk("x0_stall", {StallF, FlushE}, 0);
        step();

        // load-use
        clear_in();
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; RegWriteE = 1'b1;
        #1;
        chk("lu_cnt0", StallCount, 0);
        chk("lu_stall", {StallF, StallD, FlushE, FlushD, PCSrcE}, 5'b11100);
        step();
        ResultSrcE = 2'b00; RdE = 5'd0; RegWriteE = 1'b0;
        #1;
        chk("lu_cnt1", StallCount, 1);
        chk("lu_drop", {StallF, StallD, FlushE}, 0);
        chk("lu_m", {ResultSrcM, RdM}, {2'b01, 5'd7});

        // branch taken then not taken
        clear_in();
        BranchE = 1'b1; ZeroE = 1'b1;
        #1;
        chk("br_taken", {PCSrcE, FlushD, FlushE, StallF}, 4'b1110);
        chk("br_fc0", FlushCount, 0);
        step();
        chk("br_fc1", FlushCount, 1);
        ZeroE = 1'b0;
        #1;
        chk("br_nt", {PCSrcE, FlushD, FlushE}, 0);
        step();
        chk("br_nt_fc", FlushCount, 1);

        // load-use together with a jump: redirect wins
        clear_in();
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; JumpE = 1'b1;
        #1;
        chk("both_ctl", {StallF, StallD, FlushD, FlushE}, 4'b0011);
        step();
        chk("both_cnt", {StallCount, FlushCount}, {4'd1, 4'd2});

        // saturation
        clear_in();
        JumpE = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("sat_15", FlushCount, 15);
        step();
        chk("sat_hold", FlushCount, 15);
        chk("sat_sc", StallCount, 1);

        // reset mid-stream drops in-flight writes at once
        clear_in();
        RegWriteE = 1'b1; RdE = 5'd9;
        step();
        step();
        chk("mid_pre", {RegWriteM, RegWriteW, RdW}, {1'b1, 1'b1, 5'd9});
        #2 reset = 1'b0;
        #1;
        chk("mid_regw", {RegWriteM, RegWriteW}, 0);
        chk("mid_cnt", {StallCount, FlushCount}, 0);
        #1 reset = 1'b1;
        #1;
        chk("mid_rel", {RegWriteM, RdM, FlushCount}, 0);
        step();
        chk("mid_after", {RegWriteM, RdM}, {1'b1, 5'd9});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
